// File: rtl/jts16_obj_scan.sv
// Per-line sprite table scanner: walks object RAM, issues draw requests, updates running ROM addresses.
// Optional JTS16_OBJ_SCAN_LIMIT_EN caps draw requests at 32 per line.
module jts16_obj_scan #(
    parameter int              MAXOBJ  = 128,
    parameter logic signed [8:0] VOFFSET = 9'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hstart,
    input  logic [8:0]  vrender,
    output logic [9:0]  tbl_addr,
    input  logic [15:0] tbl_dout,
    output logic        tbl_we,
    output logic [15:0] tbl_din,
    output logic        dr_start,
    input  logic        dr_busy,
    output logic [8:0]  dr_xpos,
    output logic [15:0] dr_addr,
    output logic [3:0]  dr_bank,
    output logic [1:0]  dr_prio,
    output logic        dr_hflip,
    output logic [5:0]  dr_pal,
    output logic        scan_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_CHK,
        S_F1,
        S_F2,
        S_F3,
        S_F4,
        S_F7,
        S_WB,
        S_REQ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [7:0]  line_q, line_d;
    logic [7:0]  top_q, top_d;
    logic [8:0]  xpos_q, xpos_d;
    logic [15:0] pitch_q, pitch_d;
    logic [15:0] run_q, run_d;
    logic [12:0] attr_q, attr_d;

    logic [8:0]  o_xpos_q;
    logic [15:0] o_addr_q;
    logic [3:0]  o_bank_q;
    logic [1:0]  o_prio_q;
    logic        o_hflip_q;
    logic [5:0]  o_pal_q;

`ifdef JTS16_OBJ_SCAN_LIMIT_EN
    logic [5:0]  nreq_q, nreq_d;
`endif

    logic [9:0]  addr_c;
    logic        we_c;
    logic [15:0] din_c;
    logic        start_c;
    logic [7:0]  line_nx;
    logic [7:0]  w_top;
    logic [7:0]  w_bot;
    logic        hit;
    logic        limit_hit;

    assign line_nx = 8'(vrender + 9'd1 + VOFFSET);
    assign w_top   = tbl_dout[7:0];
    assign w_bot   = tbl_dout[15:8];
    // Half-open span: top==bottom and bottom<top can never match
    assign hit     = (w_top <= line_q) && (line_q < w_bot);

`ifdef JTS16_OBJ_SCAN_LIMIT_EN
    assign limit_hit = (nreq_q == 6'd32);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        top_d   = top_q;
        xpos_d  = xpos_q;
        pitch_d = pitch_q;
        run_d   = run_q;
        attr_d  = attr_q;
        addr_c  = 10'd0;
        we_c    = 1'b0;
        din_c   = 16'd0;
        start_c = 1'b0;
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
        nreq_d  = nreq_q;
`endif
        unique case (state_q)
            S_IDLE: begin
            end
            S_RD0: begin
                addr_c  = {cnt_q, 3'd0};
                state_d = S_CHK;
            end
            S_CHK: begin
                addr_c = {cnt_q, 3'd1};
                top_d  = w_top;
                if (w_bot == 8'hFF) begin
                    state_d = S_DONE;
                end else if (hit) begin
                    state_d = limit_hit ? S_DONE : S_F1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_F1: begin
                addr_c  = {cnt_q, 3'd2};
                xpos_d  = tbl_dout[8:0];
                state_d = S_F2;
            end
            S_F2: begin
                addr_c  = {cnt_q, 3'd3};
                pitch_d = tbl_dout;
                state_d = S_F3;
            end
            S_F3: begin
                addr_c = {cnt_q, 3'd4};
                if (line_q == top_q) begin
                    run_d = tbl_dout;
                end
                state_d = S_F4;
            end
            S_F4: begin
                addr_c  = {cnt_q, 3'd7};
                attr_d  = {tbl_dout[15:12], tbl_dout[8:0]};
                state_d = S_F7;
            end
            S_F7: begin
                if (line_q != top_q) begin
                    run_d = tbl_dout;
                end
                state_d = S_WB;
            end
            S_WB: begin
                addr_c  = {cnt_q, 3'd7};
                we_c    = 1'b1;
                din_c   = run_q + pitch_q;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (!dr_busy) begin
                    start_c = 1'b1;
                    state_d = S_NEXT;
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
                    nreq_d  = nreq_q + 6'd1;
`endif
                end
            end
            S_NEXT: begin
                if (cnt_q == 7'(MAXOBJ - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = S_RD0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new line always wins; a write already on the bus still lands
        if (hstart) begin
            state_d = S_RD0;
            cnt_d   = 7'd0;
            line_d  = line_nx;
            start_c = 1'b0;
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
            nreq_d  = 6'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 7'd0;
            line_q    <= 8'd0;
            top_q     <= 8'd0;
            xpos_q    <= 9'd0;
            pitch_q   <= 16'd0;
            run_q     <= 16'd0;
            attr_q    <= 13'd0;
            o_xpos_q  <= 9'd0;
            o_addr_q  <= 16'd0;
            o_bank_q  <= 4'd0;
            o_prio_q  <= 2'd0;
            o_hflip_q <= 1'b0;
            o_pal_q   <= 6'd0;
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
            nreq_q    <= 6'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            top_q   <= top_d;
            xpos_q  <= xpos_d;
            pitch_q <= pitch_d;
            run_q   <= run_d;
            attr_q  <= attr_d;
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
            nreq_q  <= nreq_d;
`endif
            if (start_c) begin
                o_xpos_q  <= xpos_q;
                o_addr_q  <= run_q;
                o_bank_q  <= attr_q[12:9];
                o_prio_q  <= attr_q[7:6];
                o_hflip_q <= attr_q[8];
                o_pal_q   <= attr_q[5:0];
            end
        end
    end

    // Fields switch with the pulse itself and then hold until the next one
    assign dr_xpos   = start_c ? xpos_q       : o_xpos_q;
    assign dr_addr   = start_c ? run_q        : o_addr_q;
    assign dr_bank   = start_c ? attr_q[12:9] : o_bank_q;
    assign dr_prio   = start_c ? attr_q[7:6]  : o_prio_q;
    assign dr_hflip  = start_c ? attr_q[8]    : o_hflip_q;
    assign dr_pal    = start_c ? attr_q[5:0]  : o_pal_q;

    assign dr_start  = start_c;
    assign tbl_addr  = addr_c;
    assign tbl_we    = we_c;
    assign tbl_din   = din_c;
    assign scan_busy = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_jts16_obj_scan.sv
// Scoreboard bench for jts16_obj_scan: table model predicts draw requests and write-backs.
module tb_jts16_obj_scan;

`ifdef JTS16_OBJ_SCAN_LIMIT_EN
    localparam int REQ_LIMIT = 32;
`else
    localparam int REQ_LIMIT = 1 << 30;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hstart = 1'b0;
    logic [8:0]  vrender = 9'd0;
    logic [9:0]  tbl_addr;
    logic [15:0] tbl_dout;
    logic        tbl_we;
    logic [15:0] tbl_din;
    logic        dr_start;
    logic        dr_busy = 1'b0;
    logic [8:0]  dr_xpos;
    logic [15:0] dr_addr;
    logic [3:0]  dr_bank;
    logic [1:0]  dr_prio;
    logic        dr_hflip;
    logic [5:0]  dr_pal;
    logic        scan_busy;

    jts16_obj_scan dut (
        .clk       (clk),
        .rst       (rst),
        .hstart    (hstart),
        .vrender   (vrender),
        .tbl_addr  (tbl_addr),
        .tbl_dout  (tbl_dout),
        .tbl_we    (tbl_we),
        .tbl_din   (tbl_din),
        .dr_start  (dr_start),
        .dr_busy   (dr_busy),
        .dr_xpos   (dr_xpos),
        .dr_addr   (dr_addr),
        .dr_bank   (dr_bank),
        .dr_prio   (dr_prio),
        .dr_hflip  (dr_hflip),
        .dr_pal    (dr_pal),
        .scan_busy (scan_busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    logic [15:0] mdl [0:1023];
    logic        host_we = 1'b0;
    logic [9:0]  host_a = 10'd0;
    logic [15:0] host_d = 16'd0;

    always @(posedge clk) begin
        if (host_we) mem[host_a] <= host_d;
        else if (tbl_we) mem[tbl_addr] <= tbl_din;
        tbl_dout <= mem[tbl_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int n_starts = 0;
    int n_we = 0;
    int busy_mode = 0;
    bit sb_on = 1'b1;
    logic [9:0]  max_addr = 10'd0;
    logic [37:0] last_fields = '0;
    logic [37:0] exp_q [$];
    logic [25:0] wr_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] cur_fields();
        return {dr_xpos, dr_addr, dr_bank, dr_prio, dr_hflip, dr_pal};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        dr_busy = (busy_mode == 1) || (busy_mode == 2 && $urandom_range(0, 3) == 0);
    end

    // Monitor: pops expectations whenever the DUT issues a request or a write
    always @(negedge clk) begin
        if (dr_start) begin
            n_starts++;
            last_fields = cur_fields();
            chk("start_while_busy", {63'd0, dr_busy}, 64'd0);
            if (sb_on) begin
                if (exp_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
                else chk("draw_fields", {26'd0, cur_fields()}, {26'd0, exp_q.pop_front()});
            end
        end
        if (tbl_we) begin
            n_we++;
            if (sb_on) begin
                if (wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
                else chk("writeback", {38'd0, tbl_addr, tbl_din}, {38'd0, wr_q.pop_front()});
            end
        end
        if (scan_busy && tbl_addr > max_addr) max_addr = tbl_addr;
    end

    task automatic hwr(input logic [9:0] a, input logic [15:0] d);
        host_a = a;
        host_d = d;
        host_we = 1'b1;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    task automatic set_entry(input int n, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4, input logic [15:0] w7);
        logic [15:0] w [6];
        int off [6];
        w = '{w0, w1, w2, w3, w4, w7};
        off = '{0, 1, 2, 3, 4, 7};
        for (int i = 0; i < 6; i++) begin
            mdl[n * 8 + off[i]] = w[i];
            hwr(10'(n * 8 + off[i]), w[i]);
        end
    endtask

    task automatic clear_table();
        for (int n = 0; n < 128; n++) begin
            mdl[n * 8] = 16'h0000;
            hwr(10'(n * 8), 16'h0000);
        end
    endtask

    // Reference: sprites whose [top,bottom) span holds the next line, in table order
    task automatic model_line(input logic [8:0] vr, output int nreq);
        logic [7:0] L, top, bot;
        logic [15:0] a, nw;
        int b;
        L = 8'(vr + 9'd1);
        nreq = 0;
        for (int n = 0; n < 128; n++) begin
            b = n * 8;
            bot = mdl[b][15:8];
            top = mdl[b][7:0];
            if (bot == 8'hFF) break;
            if (top <= L && L < bot) begin
                if (nreq == REQ_LIMIT) break;
                a = (L == top) ? mdl[b + 3] : mdl[b + 7];
                nw = a + mdl[b + 2];
                exp_q.push_back({mdl[b + 1][8:0], a, mdl[b + 4][15:12], mdl[b + 4][7:6],
                                 mdl[b + 4][8], mdl[b + 4][5:0]});
                wr_q.push_back({10'(b + 7), nw});
                mdl[b + 7] = nw;
                nreq++;
            end
        end
    endtask

    task automatic pulse_hstart();
        @(posedge clk);
        #1;
        hstart = 1'b1;
        @(posedge clk);
        #1;
        hstart = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!scan_busy) break;
        end
        if (i == 20000) chk("scan_timeout", 64'd1, 64'd0);
    endtask

    task automatic start_line(input logic [8:0] vr, output int nexp, output int s0);
        vrender = vr;
        model_line(vr, nexp);
        s0 = n_starts;
        pulse_hstart();
    endtask

    task automatic finish_line(input int nexp, input int s0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("line_starts", 64'(n_starts - s0), 64'(nexp));
        chk("sb_drained", 64'(exp_q.size() + wr_q.size()), 64'd0);
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic run_line(input logic [8:0] vr);
        int ne, s0;
        start_line(vr, ne, s0);
        finish_line(ne, s0);
    endtask

    initial begin
        int ne, s0, w0c, i;
        logic [7:0] top, bot;
        logic [37:0] snap;

        repeat (3) @(negedge clk);
        chk("rst_tbl_addr", 64'(tbl_addr), 64'd0);
        chk("rst_tbl_we", 64'(tbl_we), 64'd0);
        chk("rst_tbl_din", 64'(tbl_din), 64'd0);
        chk("rst_dr_start", 64'(dr_start), 64'd0);
        chk("rst_fields", {26'd0, cur_fields()}, 64'd0);
        chk("rst_scan_busy", 64'(scan_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        clear_table();
        set_entry(0, {8'd20, 8'd10}, 16'h0055, 16'h0020, 16'h1000, 16'hA1C5, 16'h7777);
        set_entry(1, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        run_line(9'd9);
        chk("t1_addr", 64'(last_fields[28:13]), 64'h1000);
        chk("t1_w7", 64'(mem[7]), 64'h1020);
        run_line(9'd10);
        chk("t2_addr", 64'(last_fields[28:13]), 64'h1020);
        chk("t2_w7", 64'(mem[7]), 64'h1040);
        s0 = n_starts;
        run_line(9'd19);
        chk("t3_nodraw", 64'(n_starts - s0), 64'd0);
        chk("t3_w7", 64'(mem[7]), 64'h1040);

        clear_table();
        set_entry(2, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        max_addr = 10'd0;
        run_line(9'd30);
        chk("endmark_reads", 64'(max_addr < 10'd24), 64'd1);

        clear_table();
        set_entry(0, {8'd50, 8'd40}, 16'h0123, 16'h0008, 16'h4440, 16'h5E2A, 16'h9999);
        set_entry(1, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        busy_mode = 1;
        @(negedge clk);
        snap = last_fields;
        start_line(9'd39, ne, s0);
        repeat (50) @(negedge clk);
        chk("busy_nostart", 64'(n_starts - s0), 64'd0);
        chk("busy_hold", {26'd0, cur_fields()}, {26'd0, snap});
        busy_mode = 0;
        finish_line(ne, s0);
        chk("busy_addr", 64'(last_fields[28:13]), 64'h4440);

        clear_table();
        for (int n = 0; n < 40; n++)
            set_entry(n, {8'd100, 8'd5}, 16'($urandom), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom));
        set_entry(45, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        busy_mode = 2;
        start_line(9'd49, ne, s0);
`ifdef JTS16_OBJ_SCAN_LIMIT_EN
        chk("limit_model", 64'(ne), 64'd32);
`else
        chk("limit_model", 64'(ne), 64'd40);
`endif
        finish_line(ne, s0);

        for (int t = 0; t < 3; t++) begin
            for (int n = 0; n < 128; n++) begin
                top = 8'($urandom_range(0, 60));
                if ($urandom_range(0, 7) == 0) bot = 8'($urandom_range(0, int'(top)));
                else bot = top + 8'($urandom_range(0, 30));
                set_entry(n, {bot, top}, 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom));
            end
            if (t == 1) set_entry($urandom_range(20, 100), 16'hFF00, 16'h0, 16'h0, 16'h0,
                                  16'h0, 16'h0);
            for (int l = 0; l < 5; l++)
                run_line((l == 4) ? 9'h1FF : 9'($urandom_range(0, 80)));
        end

        busy_mode = 0;
        sb_on = 1'b0;
        clear_table();
        set_entry(5, {8'd30, 8'd10}, 16'h0011, 16'h0010, 16'h2000, 16'h0000, 16'h3000);
        set_entry(6, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        vrender = 9'd14;
        w0c = n_we;
        s0 = n_starts;
        pulse_hstart();
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tbl_addr == 10'd42) break;
        end
        if (i == 200) chk("abort_reach_timeout", 64'd1, 64'd0);
        pulse_hstart();
        @(negedge clk);
        chk("abort_addr", 64'(tbl_addr), 64'd0);
        chk("abort_busy", 64'(scan_busy), 64'd1);
        chk("abort_no_wb", 64'(n_we - w0c), 64'd0);
        wait_idle();
        chk("abort_wb_once", 64'(n_we - w0c), 64'd1);
        chk("abort_start_once", 64'(n_starts - s0), 64'd1);
        chk("abort_w7", 64'(mem[47]), 64'h3010);

        pulse_hstart();
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tbl_we) break;
        end
        if (i == 200) chk("wb_reach_timeout", 64'd1, 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_wb_we", 64'(tbl_we), 64'd0);
        chk("rst_wb_start", 64'(dr_start), 64'd0);
        chk("rst_wb_busy", 64'(scan_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_w7", 64'(mem[47]), 64'h3010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
